// File: rtl/reg32_shift_ctrl_pkg.sv
// Shared definitions for the reg_32 command sequencer: FSM states, command codes,
// register mode codes and control-pin levels.
package reg32_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_SHIFT  = 2'b10,
        ST_FINISH = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SHIFT  = 2'b01,
        OP_ROTATE = 2'b10,
        OP_CLEAR  = 2'b11
    } cmd_op_t;

    localparam logic [1:0] MODO_00 = 2'b00;  // shift
    localparam logic [1:0] MODO_01 = 2'b01;  // rotate
    localparam logic [1:0] MODO_10 = 2'b10;  // parallel load

    localparam logic ENABLE   = 1'b1;
    localparam logic LOW      = 1'b0;
    localparam logic HIGH     = 1'b1;
    localparam logic DIR_LEFT = HIGH;

endpackage

// File: rtl/reg32_step_cnt.sv
// Loadable down-counter for shift/rotate steps; load value saturates at MAX_VAL,
// decrement stops at zero.
module reg32_step_cnt #(
    parameter int CNT_W   = 6,
    parameter int MAX_VAL = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             is_one,
    output logic             is_zero
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val > MAX_C) ? MAX_C : load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_one  = (cnt == CNT_W'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/reg32_shift_ctrl.sv
// Command sequencer driving one reg_32 instance (load/clear/shift/rotate, DONE pulse).
// Define REG32_SHIFT_CTRL_CAPTURE_EN to capture Q into RESULT at command completion.
module reg32_shift_ctrl
    import reg32_shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 6,
    parameter int MAX_SHIFT = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic             CMD_DIR,
    input  logic             CMD_SIN,
    input  logic [CNT_W-1:0] CMD_CNT,
    input  logic [WIDTH-1:0] CMD_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             ENB,
    output logic             DIR,
    output logic             S_IN,
    output logic [1:0]       MODO,
    output logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic [7:0]       S_OUT,
    output logic [WIDTH-1:0] RESULT
);

    state_t           state;
    logic             accept;
    logic [CNT_W-1:0] step_cnt;
    logic             cnt_one;
    logic             cnt_zero;

    assign accept = (state == ST_IDLE) && CMD_VALID && CMD_READY;

    reg32_step_cnt #(
        .CNT_W  (CNT_W),
        .MAX_VAL(MAX_SHIFT)
    ) u_step_cnt (
        .clk     (CLK),
        .rst     (RST),
        .load    (accept),
        .dec     (state == ST_SHIFT),
        .load_val(CMD_CNT),
        .cnt     (step_cnt),
        .is_one  (cnt_one),
        .is_zero (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            ENB       <= ~ENABLE;
            DIR       <= LOW;
            S_IN      <= LOW;
            MODO      <= MODO_10;
            D         <= '0;
            DONE      <= 1'b0;
            BUSY      <= 1'b0;
            CMD_READY <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    CMD_READY <= 1'b1;
                    BUSY      <= 1'b0;
                    if (accept) begin
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        case (cmd_op_t'(CMD_OP))
                            OP_LOAD, OP_CLEAR: begin
                                state <= ST_LOAD;
                                ENB   <= ENABLE;
                                MODO  <= MODO_10;
                                D     <= (cmd_op_t'(CMD_OP) == OP_CLEAR) ? '0 : CMD_DATA;
                            end
                            default: begin
                                DIR  <= CMD_DIR;
                                S_IN <= CMD_SIN;
                                MODO <= (cmd_op_t'(CMD_OP) == OP_SHIFT) ? MODO_00 : MODO_01;
                                // A zero step count completes without ever enabling the register
                                if (CMD_CNT == '0) begin
                                    state <= ST_FINISH;
                                end else begin
                                    state <= ST_SHIFT;
                                    ENB   <= ENABLE;
                                end
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    state <= ST_FINISH;
                    ENB   <= ~ENABLE;
                end
                ST_SHIFT: begin
                    if (cnt_one || cnt_zero) begin
                        state <= ST_FINISH;
                        ENB   <= ~ENABLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    DONE      <= 1'b1;
                    BUSY      <= 1'b0;
                    CMD_READY <= 1'b1;
                end
            endcase
        end
    end

`ifdef REG32_SHIFT_CTRL_CAPTURE_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT <= '0;
        end else if (state == ST_FINISH) begin
            RESULT <= Q;
        end
    end
`else
    assign RESULT = '0;
`endif

    // Serial output bus (and Q when capture is off) has no consumer here
    logic unused_in;
    assign unused_in = ^{S_OUT, Q, step_cnt};

endmodule

// File: tb/tb_reg32_shift_ctrl.sv
// Scoreboard bench for reg32_shift_ctrl with a behavioural reg_32 attached.
module tb_reg32_shift_ctrl;
    import reg32_shift_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_OP = 2'b00;
    logic        CMD_DIR = 1'b0;
    logic        CMD_SIN = 1'b0;
    logic [5:0]  CMD_CNT = '0;
    logic [31:0] CMD_DATA = '0;
    logic        BUSY, DONE, ENB, DIR, S_IN;
    logic [1:0]  MODO;
    logic [31:0] D, Q, RESULT;
    logic [7:0]  S_OUT;

    always #5 CLK = ~CLK;

    reg32_shift_ctrl dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DIR(CMD_DIR), .CMD_SIN(CMD_SIN), .CMD_CNT(CMD_CNT),
        .CMD_DATA(CMD_DATA), .BUSY(BUSY), .DONE(DONE), .ENB(ENB), .DIR(DIR),
        .S_IN(S_IN), .MODO(MODO), .D(D), .Q(Q), .S_OUT(S_OUT), .RESULT(RESULT)
    );

    // reg_32 model; not touched by the controller reset
    always @(posedge CLK) begin
        if (ENB === ENABLE) begin
            case (MODO)
                MODO_00: Q <= (DIR == DIR_LEFT) ? {Q[30:0], S_IN} : {S_IN, Q[31:1]};
                MODO_01: Q <= (DIR == DIR_LEFT) ? {Q[30:0], Q[31]} : {Q[0], Q[31:1]};
                MODO_10: Q <= D;
                default: ;
            endcase
        end
    end
    assign S_OUT = (DIR == DIR_LEFT) ? Q[31:24] : Q[7:0];

    typedef struct {
        logic [31:0] q;
        int          lat;
        int          enb;
        logic [1:0]  modo;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   enb_cnt = 0;
    logic [1:0] modo_seen = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: latency counted from the accepting edge to the edge that raises DONE
    always @(negedge CLK) begin
        exp_t e;
        int   a;
        cyc++;
        if (RST) begin
            acc_q.delete();
            enb_cnt = 0;
        end else begin
            if (ENB === ENABLE) begin
                enb_cnt++;
                modo_seen = MODO;
            end
            if (CMD_VALID && CMD_READY) begin
                chk("accept_while_busy", {63'd0, BUSY}, 64'd0);
                acc_q.push_back(cyc);
            end
            if (DONE === 1'b1) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL done_unexpected: got DONE=1, expected no DONE");
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("q_at_done", {32'd0, Q}, {32'd0, e.q});
                    chk("done_latency", 64'(cyc - a - 1), 64'(e.lat));
                    chk("enb_cycles", 64'(enb_cnt), 64'(e.enb));
                    if (e.enb > 0) chk("modo", {62'd0, modo_seen}, {62'd0, e.modo});
`ifdef REG32_SHIFT_CTRL_CAPTURE_EN
                    chk("result", {32'd0, RESULT}, {32'd0, e.q});
`else
                    chk("result", {32'd0, RESULT}, 64'd0);
`endif
                end
                enb_cnt = 0;
            end
        end
    end

    task automatic expect_cmd(input logic [31:0] q, input int lat, input int enb, input logic [1:0] modo);
        exp_t e;
        e.q = q; e.lat = lat; e.enb = enb; e.modo = modo;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic dir, input logic sin,
                         input logic [5:0] cnt, input logic [31:0] data, output logic done_at_acc);
        bit ok = 0;
        done_at_acc = 1'b0;
        @(posedge CLK); #1;
        CMD_OP = op; CMD_DIR = dir; CMD_SIN = sin; CMD_CNT = cnt; CMD_DATA = data;
        CMD_VALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (CMD_READY) begin
                done_at_acc = DONE;
                @(posedge CLK); #1;
                ok = 1;
                break;
            end
        end
        CMD_VALID = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got READY=0 for 200 cycles, expected READY=1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0) break;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic d;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_enb",    {63'd0, ENB},  {63'd0, ~ENABLE});
        chk("rst_modo",   {62'd0, MODO}, {62'd0, MODO_10});
        chk("rst_d",      {32'd0, D},    64'd0);
        chk("rst_done",   {63'd0, DONE}, 64'd0);
        chk("rst_busy",   {63'd0, BUSY}, 64'd0);
        chk("rst_result", {32'd0, RESULT}, 64'd0);
        chk("rst_ready",  {63'd0, CMD_READY}, 64'd1);

        expect_cmd(32'hA5A5_0F0F, 2, 1, MODO_10);
        issue(OP_LOAD, 1'b0, 1'b0, 6'd0, 32'hA5A5_0F0F, d);
        drain();

        expect_cmd(32'h0000_0001, 2, 1, MODO_10);
        issue(OP_LOAD, 1'b0, 1'b0, 6'd0, 32'h0000_0001, d);
        expect_cmd(32'h0000_0010, 5, 4, MODO_00);
        issue(OP_SHIFT, DIR_LEFT, 1'b0, 6'd4, 32'hDEAD_BEEF, d);
        drain();

        expect_cmd(32'h8000_0001, 2, 1, MODO_10);
        issue(OP_LOAD, 1'b0, 1'b0, 6'd0, 32'h8000_0001, d);
        expect_cmd(32'h8000_0001, 33, 32, MODO_01);
        issue(OP_ROTATE, DIR_LEFT, 1'b0, 6'd40, 32'h0, d);
        drain();

        expect_cmd(32'h8000_0001, 1, 0, MODO_00);
        issue(OP_SHIFT, ~DIR_LEFT, 1'b1, 6'd0, 32'h0, d);
        drain();

        expect_cmd(32'h0000_0000, 2, 1, MODO_10);
        issue(OP_CLEAR, 1'b0, 1'b0, 6'd0, 32'hFFFF_FFFF, d);
        drain();

        expect_cmd(32'h0000_00F0, 2, 1, MODO_10);
        issue(OP_LOAD, 1'b0, 1'b0, 6'd0, 32'h0000_00F0, d);
        expect_cmd(32'hE000_001E, 4, 3, MODO_00);
        issue(OP_SHIFT, ~DIR_LEFT, 1'b1, 6'd3, 32'h0, d);
        expect_cmd(32'hEE00_0001, 5, 4, MODO_01);
        issue(OP_ROTATE, ~DIR_LEFT, 1'b0, 6'd4, 32'h0, d);
        drain();

        // Second command offered while the shift is still running
        expect_cmd(32'h0000_0001, 2, 1, MODO_10);
        issue(OP_LOAD, 1'b0, 1'b0, 6'd0, 32'h0000_0001, d);
        drain();
        expect_cmd(32'h0000_0007, 3, 2, MODO_00);
        issue(OP_SHIFT, DIR_LEFT, 1'b1, 6'd2, 32'h0, d);
        expect_cmd(32'h0000_0055, 2, 1, MODO_10);
        issue(OP_LOAD, 1'b0, 1'b0, 6'd0, 32'h0000_0055, d);
        chk("b2b_accept_with_done", {63'd0, d}, 64'd1);
        drain();

        // Abort a 10-step shift with reset during its third enabled cycle
        expect_cmd(32'h0000_0001, 2, 1, MODO_10);
        issue(OP_LOAD, 1'b0, 1'b0, 6'd0, 32'h0000_0001, d);
        drain();
        issue(OP_SHIFT, DIR_LEFT, 1'b0, 6'd10, 32'h0, d);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_enb",  {63'd0, ENB},  {63'd0, ~ENABLE});
        chk("abort_busy", {63'd0, BUSY}, 64'd0);
        chk("abort_done", {63'd0, DONE}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_ready", {63'd0, CMD_READY}, 64'd1);
        chk("abort_q",     {32'd0, Q}, 64'h0000_0008);

        expect_cmd(32'h1234_ABCD, 2, 1, MODO_10);
        issue(OP_LOAD, 1'b0, 1'b0, 6'd0, 32'h1234_ABCD, d);
        drain();
        repeat (3) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
